// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst-limited sharing of one FIFO write port between two pixel producers
module fifo_write_arbiter #(
    parameter int PIX_WIDTH  = 16,
    parameter int MEM_LENGTH = 8,
    parameter int FULL_LEVEL = 255,
    parameter int BURST      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [PIX_WIDTH-1:0]  pix0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [PIX_WIDTH-1:0]  pix1,
    output logic                  ack1,
    input  logic [MEM_LENGTH-1:0] fill,
    output logic                  wr_en,
    output logic [PIX_WIDTH-1:0]  wr_pix,
    output logic                  grant_id,
    output logic                  busy
);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [PIX_WIDTH-1:0]  wr_pix_q, wr_pix_d;
    logic [MEM_LENGTH:0]   level;
    logic                  space, granted, g, own_req, oth_req, acc, done;
    logic [1:0]            other;

    // the registered write still in flight is not yet visible in fill
    assign level   = {1'b0, fill} + {{MEM_LENGTH{1'b0}}, wr_en_q};
    assign space   = level < (MEM_LENGTH + 1)'(FULL_LEVEL);
    assign ack0    = !reset && state_q == GRANT0 && req0 && space;
    assign ack1    = !reset && state_q == GRANT1 && req1 && space;
    assign granted = state_q == GRANT0 || state_q == GRANT1;
    assign g       = state_q == GRANT1;
    assign own_req = g ? req1 : req0;
    assign oth_req = g ? req0 : req1;
    assign other   = g ? GRANT0 : GRANT1;
    assign acc     = ack0 | ack1;
    assign done    = acc && cnt_q == CW'(BURST - 1);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        wr_en_d  = acc;
        wr_pix_d = ack1 ? pix1 : ack0 ? pix0 : wr_pix_q;
        if (granted) begin
            if (!own_req) begin
                state_d = oth_req ? other : IDLE;
                last_d  = g;
                cnt_d   = '0;
            end else if (done) begin
                cnt_d = '0;
                if (oth_req) begin
                    state_d = other;
                    last_d  = g;
                end
            end else if (acc) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            state_d = (req0 && (last_q || !req1)) ? GRANT0 : req1 ? GRANT1 : IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_pix_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            wr_pix_q <= wr_pix_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_pix   = wr_pix_q;
    assign grant_id = g;
    assign busy     = granted;
endmodule
